// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: register map, STATUS/CTRL bit indices and FSM states for apb_uart_tx
package uart_tx_pkg;
  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CTRL_OFS   = 4'h8;
  localparam logic [3:0] DIV_OFS    = 4'hC;
  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 4;
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO is taken only alongside a pop
module tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/apb_uart_tx.sv
// apb_uart_tx: APB slave with an 8N1 UART transmitter behind a TX FIFO and an idle/drained interrupt
module apb_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        TXD,
  output logic        INTR
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [3:0] ofs;
  logic wr, push, pop, full, empty, ovf, tx_en, irq_en, bit_end, load, txd_n;
  logic [15:0] div, wdiv, baud, baud_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n, fifo_dout;
  logic [CW-1:0] count;
  logic [31:0] status, rdata;
  logic unused_bits;
  state_t state, state_n;
  assign ofs         = {PADDR[3:2], 2'b00};
  assign wr          = PSEL & PENABLE & PWRITE;
  assign push        = wr & (ofs == TXDATA_OFS);
  assign wdiv        = (PWDATA[15:0] < 16'd2) ? 16'd2 : PWDATA[15:0];
  assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};
  tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(PCLK), .rst_n(PRESETn), .push(push), .pop(pop), .din(PWDATA[7:0]),
    .dout(fifo_dout), .count(count), .full(full), .empty(empty)
  );
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tx_en  <= 1'b0;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      div    <= 16'(CLK_DIV);
    end else begin
      if (wr && ofs == CTRL_OFS) begin
        tx_en  <= PWDATA[CTRL_TX_EN];
        irq_en <= PWDATA[CTRL_IRQ_EN];
      end
      if (wr && ofs == DIV_OFS) div <= wdiv;
      if (push && full && !pop) ovf <= 1'b1;
      else if (wr && ofs == STATUS_OFS && PWDATA[ST_OVF]) ovf <= 1'b0;
    end
  end
  assign bit_end = baud == '0;
  assign load    = tx_en & ~empty;
  // The baud counter reloads from div only at bit boundaries, so DIV writes never stretch a bit in flight.
  always_comb begin
    state_n   = state;
    baud_n    = baud - 16'd1;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_n = baud;
        if (load) begin
          pop     = 1'b1;
          shreg_n = fifo_dout;
          baud_n  = div - 16'd1;
          state_n = START;
        end
      end
      START: if (bit_end) begin
        baud_n    = div - 16'd1;
        bit_cnt_n = '0;
        state_n   = DATA;
      end
      DATA: if (bit_end) begin
        baud_n    = div - 16'd1;
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt + 3'd1;
        state_n   = (bit_cnt == 3'd7) ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        baud_n  = div - 16'd1;
        pop     = load;
        shreg_n = load ? fifo_dout : shreg;
        state_n = load ? START : IDLE;
      end
      default: state_n = IDLE;
    endcase
    txd_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? shreg_n[0] : 1'b1;
  end
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      TXD     <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      TXD     <= txd_n;
    end
  end
  assign status = {24'b0, 4'(count), ovf, empty, full, state != IDLE};
  assign rdata  = (ofs == STATUS_OFS) ? status :
                  (ofs == CTRL_OFS)   ? {30'b0, irq_en, tx_en} :
                  (ofs == DIV_OFS)    ? {16'b0, div} : 32'b0;
  assign PRDATA = PSEL ? rdata : 32'b0;
  assign PREADY = 1'b1;
  assign INTR   = irq_en & empty & (state == IDLE);
endmodule

// File: tb/tb_apb_uart_tx.sv
// tb_apb_uart_tx: randomized scenarios checked against a frame-level model of the UART line
module tb_apb_uart_tx;
  localparam logic [3:0] A_TX = 4'h0, A_ST = 4'h4, A_CTRL = 4'h8, A_DIV = 4'hC;
  localparam int NEVER = 1 << 30;
  logic PCLK = 0, PRESETn = 0, PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [3:0] PADDR = 0;
  logic [31:0] PWDATA = 0;
  logic [31:0] PRDATA;
  logic PREADY, TXD, INTR;
  int tests = 0, fails = 0;
  logic [7:0] tx_bytes[$];
  bit exp_w[$];
  bit obs[$];

  apb_uart_tx #(.CLK_DIV(104), .FIFO_DEPTH(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .TXD(TXD), .INTR(INTR)
  );

  always #5 PCLK = ~PCLK;

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1; PWRITE = 1; PADDR = a; PWDATA = d; PENABLE = 0;
    @(negedge PCLK);
    PENABLE = 1;
    @(posedge PCLK);
    #1 PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1; PWRITE = 0; PADDR = a; PENABLE = 0;
    @(negedge PCLK);
    PENABLE = 1;
    #1 d = PRDATA;
    @(posedge PCLK);
    #1 PSEL = 0; PENABLE = 0;
  endtask

  // Line model: frames of start, 8 data bits LSB first, stop; each bit lasts the divisor
  // in force when it begins (d_new for bits starting strictly after cycle sw of the first frame).
  task automatic build_wave(input int d_old, input int d_new, input int sw);
    int t;
    logic [7:0] cur;
    bit v;
    int w;
    exp_w = {};
    t = 0;
    foreach (tx_bytes[f]) begin
      cur = tx_bytes[f];
      for (int i = 0; i < 10; i++) begin
        v = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : cur[i-1];
        w = (t > sw) ? d_new : d_old;
        repeat (w) exp_w.push_back(v);
        t += w;
      end
    end
  endtask

  task automatic capture(input int n);
    obs = {};
    repeat (n) begin
      @(negedge PCLK);
      obs.push_back(TXD);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    PRESETn = 0;
    repeat (3) @(negedge PCLK);
    tests++; if (TXD !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b expected 1", TXD); end
    tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL reset_intr: got %b expected 0", INTR); end
    tests++; if (PREADY !== 1'b1) begin fails++; $display("FAIL reset_pready: got %b expected 1", PREADY); end
    tests++; if (PRDATA !== 32'h0) begin fails++; $display("FAIL reset_prdata: got %h expected 0", PRDATA); end
    PRESETn = 1;
    apb_read(A_ST, r);
    tests++; if (r !== 32'h4) begin fails++; $display("FAIL reset_status: got %h expected 4", r); end
    apb_read(A_CTRL, r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h expected 0", r); end
    apb_read(A_DIV, r);
    tests++; if (r !== 32'd104) begin fails++; $display("FAIL reset_div: got %0d expected 104", r); end
    apb_write(A_DIV, 4);
    apb_write(A_CTRL, 1);
    apb_write(A_TX, 32'h00);
    repeat (12) @(negedge PCLK);
    tests++; if (TXD !== 1'b0) begin fails++; $display("FAIL midframe_txd: got %b expected 0", TXD); end
    PRESETn = 0;
    #1;
    tests++; if (TXD !== 1'b1) begin fails++; $display("FAIL async_reset_txd: got %b expected 1", TXD); end
    tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL async_reset_intr: got %b expected 0", INTR); end
    @(negedge PCLK);
    PRESETn = 1;
    apb_read(A_ST, r);
    tests++; if (r !== 32'h4) begin fails++; $display("FAIL post_reset_status: got %h expected 4", r); end
    apb_read(A_CTRL, r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL post_reset_ctrl: got %h expected 0", r); end
    apb_read(A_DIV, r);
    tests++; if (r !== 32'd104) begin fails++; $display("FAIL post_reset_div: got %0d expected 104", r); end
    repeat (5) @(negedge PCLK);
    tests++; if (TXD !== 1'b1) begin fails++; $display("FAIL post_reset_idle_txd: got %b expected 1", TXD); end
  endtask

  task automatic test_single();
    logic [7:0] b;
    int d, n;
    bit e;
    apb_write(A_DIV, 4);
    apb_write(A_CTRL, 1);
    for (int it = 0; it < 4; it++) begin
      b = (it == 0) ? 8'hA5 : 8'($urandom);
      d = (it == 0) ? 4 : int'($urandom_range(2, 6));
      if (it > 0) apb_write(A_DIV, d);
      tx_bytes = {b};
      build_wave(d, d, NEVER);
      n = 10 * d + 4;
      apb_write(A_TX, {24'b0, b});
      capture(n);
      for (int k = 0; k < n; k++) begin
        e = (k == 0 || k - 1 >= exp_w.size()) ? 1'b1 : exp_w[k-1];
        tests++;
        if (obs[k] !== e) begin fails++; $display("FAIL single_txd byte=%h div=%0d cyc=%0d: got %b expected %b", b, d, k, obs[k], e); end
      end
    end
  endtask

  task automatic test_burst_overflow();
    logic [31:0] r;
    logic [7:0] b;
    int d, n;
    bit e;
    d = int'($urandom_range(2, 5));
    apb_write(A_DIV, d);
    apb_write(A_CTRL, 0);
    tx_bytes = {};
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < 8) tx_bytes.push_back(b);
      apb_write(A_TX, {24'b0, b});
    end
    apb_read(A_ST, r);
    tests++; if (r !== 32'h8A) begin fails++; $display("FAIL burst_status_full_ovf: got %h expected 8a", r); end
    apb_read(A_TX, r);
    tests++; if (r !== 32'h0) begin fails++; $display("FAIL txdata_read: got %h expected 0", r); end
    apb_write(A_ST, 32'h8);
    apb_read(A_ST, r);
    tests++; if (r !== 32'h82) begin fails++; $display("FAIL ovf_clear_status: got %h expected 82", r); end
    build_wave(d, d, NEVER);
    n = 80 * d + 5;
    apb_write(A_CTRL, 1);
    capture(n);
    for (int k = 0; k < n; k++) begin
      e = (k == 0 || k - 1 >= exp_w.size()) ? 1'b1 : exp_w[k-1];
      tests++;
      if (obs[k] !== e) begin fails++; $display("FAIL burst_txd div=%0d cyc=%0d: got %b expected %b", d, k, obs[k], e); end
    end
    apb_read(A_ST, r);
    tests++; if (r !== 32'h4) begin fails++; $display("FAIL burst_drained_status: got %h expected 4", r); end
  endtask

  task automatic test_irq();
    bit e;
    apb_write(A_DIV, 4);
    apb_write(A_CTRL, 3);
    tests++; if (INTR !== 1'b1) begin fails++; $display("FAIL irq_idle_empty: got %b expected 1", INTR); end
    apb_write(A_TX, $urandom & 32'hFF);
    apb_write(A_TX, $urandom & 32'hFF);
    for (int k = 0; k < 85; k++) begin
      @(negedge PCLK);
      e = (k >= 79);
      tests++;
      if (INTR !== e) begin fails++; $display("FAIL irq_level cyc=%0d: got %b expected %b", k, INTR, e); end
    end
    apb_write(A_CTRL, 1);
    tests++; if (INTR !== 1'b0) begin fails++; $display("FAIL irq_disabled: got %b expected 0", INTR); end
  endtask

  task automatic test_div_edges();
    logic [31:0] r;
    logic [7:0] b;
    bit e;
    apb_write(A_DIV, 0);
    apb_read(A_DIV, r);
    tests++; if (r !== 32'd2) begin fails++; $display("FAIL div_zero_readback: got %0d expected 2", r); end
    apb_write(A_DIV, 1);
    apb_read(A_DIV, r);
    tests++; if (r !== 32'd2) begin fails++; $display("FAIL div_one_readback: got %0d expected 2", r); end
    b = 8'($urandom);
    tx_bytes = {b};
    build_wave(2, 2, NEVER);
    apb_write(A_TX, {24'b0, b});
    capture(24);
    for (int k = 0; k < 24; k++) begin
      e = (k == 0 || k - 1 >= exp_w.size()) ? 1'b1 : exp_w[k-1];
      tests++;
      if (obs[k] !== e) begin fails++; $display("FAIL div2_txd cyc=%0d: got %b expected %b", k, obs[k], e); end
    end
    apb_write(A_DIV, 4);
    b = 8'($urandom);
    tx_bytes = {b};
    build_wave(4, 8, 6);
    apb_write(A_TX, {24'b0, b});
    for (int n = 0; n < 80; n++) begin
      @(negedge PCLK);
      e = (n == 0 || n - 1 >= exp_w.size()) ? 1'b1 : exp_w[n-1];
      tests++;
      if (TXD !== e) begin fails++; $display("FAIL div_change_txd cyc=%0d: got %b expected %b", n, TXD, e); end
      if (n == 5) begin PSEL = 1; PWRITE = 1; PADDR = A_DIV; PWDATA = 8; PENABLE = 0; end
      if (n == 6) PENABLE = 1;
      if (n == 7) begin PSEL = 0; PENABLE = 0; PWRITE = 0; end
    end
    apb_read(A_DIV, r);
    tests++; if (r !== 32'd8) begin fails++; $display("FAIL div8_readback: got %0d expected 8", r); end
  endtask

  task automatic test_disable();
    logic [31:0] r;
    logic [7:0] b0;
    bit e;
    apb_write(A_DIV, 4);
    apb_write(A_CTRL, 1);
    b0 = 8'($urandom);
    tx_bytes = {b0};
    build_wave(4, 4, NEVER);
    apb_write(A_TX, {24'b0, b0});
    apb_write(A_TX, $urandom & 32'hFF);
    apb_write(A_TX, $urandom & 32'hFF);
    apb_write(A_CTRL, 0);
    capture(60);
    for (int k = 0; k < 60; k++) begin
      e = (k + 5 < exp_w.size()) ? exp_w[k+5] : 1'b1;
      tests++;
      if (obs[k] !== e) begin fails++; $display("FAIL disable_txd cyc=%0d: got %b expected %b", k, obs[k], e); end
    end
    apb_read(A_ST, r);
    tests++; if (r !== 32'h20) begin fails++; $display("FAIL disable_status: got %h expected 20", r); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_overflow();
    test_irq();
    test_div_edges();
    test_disable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
